// File: rtl/ssf_sched_pkg.sv
// Purpose: shared types and constants for the ssf core scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build option SSF_RR_ARB_EN is consumed by ssf_out_arbiter.
package ssf_sched_pkg;

  // Strobe encodings on the core and result ports.
  localparam logic [1:0] OUT_EN_VALID = 2'd1;
  localparam logic [1:0] OUT_EN_IDLE  = 2'd0;

  // Reset-release sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Width of a core index; a single core still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssf_out_arbiter.sv
// Purpose: picks one winner from the per-core result requests; flags any / multiple requests.
// Latency: combinational pick; with SSF_RR_ARB_EN the round-robin pointer updates on the grant edge.
// Backpressure: none; losers are not remembered, the caller drops them.
module ssf_out_arbiter
  import ssf_sched_pkg::*;
#(
  parameter int N = 48,
  localparam int IW = idx_w(N)
) (
`ifdef SSF_RR_ARB_EN
  input  logic          clk,
  input  logic          rst,
`endif
  input  logic [N-1:0]  req,
  output logic [IW-1:0] win_idx,
  output logic          any,
  output logic          multi
);

  // Any request, and two or more requests (clearing the lowest set bit leaves something).
  always_comb begin
    any   = |req;
    multi = |(req & (req - 1'b1));
  end

`ifdef SSF_RR_ARB_EN
  logic [IW-1:0] ptr_q;

  // Pointer remembers the last winner so the next search starts just past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IW'(N - 1);
    end else if (any) begin
      ptr_q <= win_idx;
    end
  end

  // Round-robin search starting at ptr+1, wrapping modulo N.
  always_comb begin : rr_pick
    int  j;
    logic found;
    j       = 0;
    found   = 1'b0;
    win_idx = '0;
    for (int off = 1; off <= N; off++) begin
      j = int'(ptr_q) + off;
      if (j >= N) begin
        j = j - N;
      end
      if (!found && req[j]) begin
        found   = 1'b1;
        win_idx = IW'(j);
      end
    end
  end
`else
  // Fixed priority: scanning downwards leaves the lowest requesting index as winner.
  always_comb begin
    win_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_idx = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ssf_core_scheduler.sv
// Purpose: staggered per-core reset release plus arbitration of core results onto one port.
// Latency: result port registered, 1 cycle from core strobe; core i released STAGGER*i after start.
// Backpressure: none; simultaneous results beyond the winner are dropped and counted.
// Build option SSF_RR_ARB_EN selects round-robin instead of lowest-index-first arbitration.
module ssf_core_scheduler
  import ssf_sched_pkg::*;
#(
  parameter int N_CORES = 48,
  parameter int DATA_W  = 32,
  parameter int STAGGER = 660,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [N_CORES*DATA_W-1:0]   core_io_out,
  input  logic [N_CORES*2-1:0]        core_out_en,
  output logic [N_CORES-1:0]          core_rst,
  output logic signed [DATA_W-1:0]    io_out,
  output logic [1:0]                  out_en,
  output logic [idx_w(N_CORES)-1:0]   grant_idx,
  output logic                        seq_done,
  output logic [CNT_W-1:0]            collision_cnt
);

  localparam int IW = idx_w(N_CORES);
  // Stagger counter must hold STAGGER-1; +1 keeps STAGGER==1 at a legal 1-bit width.
  localparam int SW = $clog2(STAGGER + 1);
  localparam logic [SW-1:0] STG_LAST = SW'(STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CORES - 1);

  seq_state_t          state_q, state_d;
  logic [SW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [N_CORES-1:0]  core_rst_q;

  logic [N_CORES-1:0]  req;
  logic [IW-1:0]       arb_win;
  logic                arb_any;
  logic                arb_multi;
  logic [DATA_W-1:0]   win_dat;

  // ------------------------------------------------------------------
  // Reset-release sequencer
  // ------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start only matters in IDLE; DONE is left only by rst.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == STG_LAST && idx_q == IDX_LAST) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Stagger counter, release index and per-core reset bits; released bits only ever clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rst_q <= '1;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            core_rst_q[0] <= 1'b0;
            idx_q         <= '0;
            cnt_q         <= '0;
          end
        end
        RUN: begin
          if (cnt_q == STG_LAST) begin
            cnt_q <= '0;
            if (idx_q != IDX_LAST) begin
              idx_q                     <= idx_q + 1'b1;
              core_rst_q[idx_q + 1'b1]  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    core_rst_q <= '0;
        default: core_rst_q <= '1;
      endcase
    end
  end

  // Sequencer outputs.
  always_comb begin
    seq_done = (state_q == DONE);
    core_rst = (state_q == DONE) ? '0 : core_rst_q;
  end

  // ------------------------------------------------------------------
  // Result arbitration
  // ------------------------------------------------------------------

  // Only the exact VALID code is a request; cores still in reset are not masked.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      req[i] = (core_out_en[i*2 +: 2] == OUT_EN_VALID);
    end
  end

  ssf_out_arbiter #(
    .N (N_CORES)
  ) u_arb (
`ifdef SSF_RR_ARB_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .req     (req),
    .win_idx (arb_win),
    .any     (arb_any),
    .multi   (arb_multi)
  );

  // Winner data mux.
  always_comb begin
    win_dat = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (arb_win == IW'(i)) begin
        win_dat = core_io_out[i*DATA_W +: DATA_W];
      end
    end
  end

  // Registered result port; data and index hold through idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_out    <= '0;
      out_en    <= OUT_EN_IDLE;
      grant_idx <= '0;
    end else if (arb_any) begin
      io_out    <= win_dat;
      out_en    <= OUT_EN_VALID;
      grant_idx <= arb_win;
    end else begin
      out_en    <= OUT_EN_IDLE;
    end
  end

  // Saturating count of cycles where results collided.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision_cnt <= '0;
    end else if (arb_multi && collision_cnt != '1) begin
      collision_cnt <= collision_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ssf_core_scheduler.sv
// Purpose: directed self-checking bench for ssf_core_scheduler (N=4, STAGGER=8, CNT_W=2).
// Latency: checks the 1-cycle result port and the 8-cycle release stagger.
// Backpressure: n/a; expectations follow SSF_RR_ARB_EN when it is defined.
module tb_ssf_core_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int ST = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [N*DW-1:0] core_io_out = '0;
  logic [N*2-1:0]  core_out_en = '0;
  logic [N-1:0]    core_rst;
  logic signed [DW-1:0] io_out;
  logic [1:0]      out_en;
  logic [1:0]      grant_idx;
  logic            seq_done;
  logic [CW-1:0]   collision_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ssf_core_scheduler #(
    .N_CORES (N),
    .DATA_W  (DW),
    .STAGGER (ST),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .core_io_out   (core_io_out),
    .core_out_en   (core_out_en),
    .core_rst      (core_rst),
    .io_out        (io_out),
    .out_en        (out_en),
    .grant_idx     (grant_idx),
    .seq_done      (seq_done),
    .collision_cnt (collision_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start       = 1'b0;
    core_out_en = '0;
    core_io_out = '0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drive(input int core, input logic [1:0] en, input logic [DW-1:0] dat);
    core_out_en[core*2 +: 2]   = en;
    core_io_out[core*DW +: DW] = dat;
  endtask

  initial begin
    logic [3:0] exp_rst;
    logic [1:0] exp_g;

    // ---------------- reset values ----------------
    do_reset();
    chk("rst_core_rst", 64'(core_rst), 64'hF);
    chk("rst_io_out", 64'(io_out), 64'h0);
    chk("rst_out_en", 64'(out_en), 64'h0);
    chk("rst_grant", 64'(grant_idx), 64'h0);
    chk("rst_seq_done", 64'(seq_done), 64'h0);
    chk("rst_coll", 64'(collision_cnt), 64'h0);

    // ---------------- staggered release, start mid-RUN ignored ----------------
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    chk("rel_k", 64'(core_rst), 64'hE);
    for (int e = 1; e <= 31; e++) begin
      start = (e == 3 || e == 12);
      tick();                     // edge k+e
      start = 1'b0;
      exp_rst = 4'hF << ((e / 8) + 1);
      chk($sformatf("rel_k+%0d", e), 64'(core_rst), 64'(exp_rst));
      chk($sformatf("done_k+%0d", e), 64'(seq_done), 64'h0);
    end
    tick();                       // edge k+32
    chk("done_k+32", 64'(seq_done), 64'h1);
    chk("rel_k+32", 64'(core_rst), 64'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("done_hold", 64'(seq_done), 64'h1);
    chk("rel_hold", 64'(core_rst), 64'h0);

    // ---------------- rst mid-sequence then restart ----------------
    do_reset();
    start = 1'b1;
    tick();                       // edge k
    start = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    chk("mid_pre_rst", 64'(core_rst), 64'hC);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", 64'(core_rst), 64'hF);
    chk("mid_rst_done", 64'(seq_done), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_idle", 64'(core_rst), 64'hF);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_k", 64'(core_rst), 64'hE);
    for (int e = 1; e <= 8; e++) tick();
    chk("restart_k+8", 64'(core_rst), 64'hC);

    // ---------------- single result from core 2 ----------------
    do_reset();
    drive(2, 2'd1, 32'h1234_5678);
    tick();
    drive(2, 2'd0, 32'h0);
    chk("one_io", 64'(io_out), 64'h1234_5678);
    chk("one_en", 64'(out_en), 64'h1);
    chk("one_grant", 64'(grant_idx), 64'h2);
    tick();
    chk("one_en_off", 64'(out_en), 64'h0);
    chk("one_io_hold", 64'(io_out), 64'h1234_5678);
    chk("one_grant_hold", 64'(grant_idx), 64'h2);

    // ---------------- collision cores 1 and 3, pointer at 1 ----------------
    do_reset();
    drive(1, 2'd1, 32'h11);
    tick();                       // single grant to core 1 leaves RR pointer at 1
    chk("col_pre_grant", 64'(grant_idx), 64'h1);
    drive(1, 2'd1, 32'h11);
    drive(3, 2'd1, 32'h33);
`ifdef SSF_RR_ARB_EN
    exp_g = 2'd3;
`else
    exp_g = 2'd1;
`endif
    tick();
    chk("col_g1", 64'(grant_idx), 64'(exp_g));
    chk("col_io1", 64'(io_out), (exp_g == 2'd3) ? 64'h33 : 64'h11);
    chk("col_en1", 64'(out_en), 64'h1);
    tick();
    drive(1, 2'd0, 32'h0);
    drive(3, 2'd0, 32'h0);
    chk("col_g2", 64'(grant_idx), 64'h1);
    chk("col_io2", 64'(io_out), 64'h11);
    tick();
    chk("col_cnt", 64'(collision_cnt), 64'h2);
    chk("col_en_off", 64'(out_en), 64'h0);

    // ---------------- non-VALID strobe codes are not requests ----------------
    do_reset();
    drive(0, 2'd2, 32'hDEAD_BEEF);
    tick();
    chk("bad2_en", 64'(out_en), 64'h0);
    chk("bad2_io", 64'(io_out), 64'h0);
    drive(0, 2'd3, 32'hCAFE_F00D);
    tick();
    chk("bad3_en", 64'(out_en), 64'h0);
    chk("bad3_grant", 64'(grant_idx), 64'h0);
    drive(1, 2'd2, 32'h1);
    drive(2, 2'd3, 32'h2);
    drive(3, 2'd2, 32'h3);
    tick();
    chk("bad_all_en", 64'(out_en), 64'h0);
    chk("bad_all_coll", 64'(collision_cnt), 64'h0);
    core_out_en = '0;

    // ---------------- collision counter saturation ----------------
    do_reset();
    drive(0, 2'd1, 32'hA0);
    drive(2, 2'd1, 32'hA2);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 2) chk("sat_cnt2", 64'(collision_cnt), 64'h2);
    end
    core_out_en = '0;
    tick();
    chk("sat_cnt", 64'(collision_cnt), 64'h3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard stop in case something stalls the stimulus thread.
  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete, got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
